// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp
// Flip-flop register file with N read ports, two prioritised write ports,
// optional same-cycle write-to-read bypass and a sequential scrub engine that
// zeroes every architectural register on request.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge) and asynchronous active-low reset
//   test_en_i              test enable, no functional effect
//   raddr_i / rdata_o      NumReadPorts x 5-bit read addresses / DataWidth-bit read data
//   waddr_a_i/wdata_a_i/we_a_i   write port A
//   waddr_b_i/wdata_b_i/we_b_i   write port B (wins over A on the same address)
//   scrub_req_i            request to zero all registers
//   scrub_busy_o           high while the scrub walks the registers
//   scrub_done_o           one-cycle pulse after the last register is cleared
module ibex_register_file_mp #(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumReadPorts = 2,
    parameter bit          WriteBypass  = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              test_en_i,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic [4:0]                        waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_a_i,
    input  logic [4:0]                        waddr_b_i,
    input  logic [DataWidth-1:0]              wdata_b_i,
    input  logic                              we_b_i,
    input  logic                              scrub_req_i,
    output logic                              scrub_busy_o,
    output logic                              scrub_done_o
);

    localparam int ADDR_WIDTH = RV32E ? 4 : 5;
    localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCRUB = 2'd1,
        ST_DONE  = 2'd2
    } scrub_state_e;

    scrub_state_e            state_r;
    scrub_state_e            state_next_s;
    logic [ADDR_WIDTH-1:0]   scrub_cnt_r;
    logic [ADDR_WIDTH-1:0]   scrub_cnt_next_s;
    logic                    busy_r;
    logic                    done_r;

    // Register 0 is never stored; it reads as zero through the decode below.
    logic [DataWidth-1:0]    mem_r [1:NUM_WORDS-1];

    logic [NUM_WORDS-1:1]    we_a_dec_s;
    logic [NUM_WORDS-1:1]    we_b_dec_s;
    logic [NUM_WORDS-1:1]    clr_dec_s;
    logic                    scrubbing_s;

    logic [4:0]              raddr_s  [NumReadPorts];
    logic [DataWidth-1:0]    rstore_s [NumReadPorts];
    logic                    rvalid_s [NumReadPorts];

    logic                    unused_test_en_s;
    assign unused_test_en_s = test_en_i;

    assign scrubbing_s = (state_r == ST_SCRUB);

    // Per-word write/clear strobes. Comparing the full 5-bit address against
    // each implemented index drops out-of-range RV32E writes and x0 for free.
    always_comb begin
        we_a_dec_s = '0;
        we_b_dec_s = '0;
        clr_dec_s  = '0;
        for (int r = 1; r < NUM_WORDS; r++) begin
            we_a_dec_s[r] = ~scrubbing_s & we_a_i & (waddr_a_i == 5'(r));
            we_b_dec_s[r] = ~scrubbing_s & we_b_i & (waddr_b_i == 5'(r));
            clr_dec_s[r]  = scrubbing_s & (scrub_cnt_r == ADDR_WIDTH'(r));
        end
    end

    // Register storage: scrub clear beats writes, port B beats port A.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 1; r < NUM_WORDS; r++) begin
                mem_r[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_WORDS; r++) begin
                if (clr_dec_s[r]) begin
                    mem_r[r] <= '0;
                end else if (we_b_dec_s[r]) begin
                    mem_r[r] <= wdata_b_i;
                end else if (we_a_dec_s[r]) begin
                    mem_r[r] <= wdata_a_i;
                end else begin
                    mem_r[r] <= mem_r[r];
                end
            end
        end
    end

    // Scrub FSM next-state and counter logic.
    always_comb begin
        state_next_s     = state_r;
        scrub_cnt_next_s = scrub_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (scrub_req_i) begin
                    state_next_s     = ST_SCRUB;
                    scrub_cnt_next_s = ADDR_WIDTH'(1);
                end else begin
                    state_next_s     = ST_IDLE;
                end
            end
            ST_SCRUB: begin
                if (scrub_cnt_r == LAST_IDX) begin
                    state_next_s     = ST_DONE;
                    scrub_cnt_next_s = '0;
                end else begin
                    scrub_cnt_next_s = scrub_cnt_r + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s     = ST_IDLE;
                scrub_cnt_next_s = '0;
            end
        endcase
    end

    // Scrub FSM state, counter and registered status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            scrub_cnt_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            scrub_cnt_r <= scrub_cnt_next_s;
            busy_r      <= (state_next_s == ST_SCRUB);
            done_r      <= (state_next_s == ST_DONE);
        end
    end

    assign scrub_busy_o = busy_r;
    assign scrub_done_o = done_r;

    // AND-OR read muxes with optional forwarding of the in-flight write data.
    // Forwarding only applies in IDLE: during a scrub writes are dropped, and
    // in DONE the stored view is returned.
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            raddr_s[p]  = raddr_i[5*p +: 5];
            rstore_s[p] = '0;
            for (int r = 1; r < NUM_WORDS; r++) begin
                rstore_s[p] = rstore_s[p] |
                              (mem_r[r] & {DataWidth{raddr_s[p] == 5'(r)}});
            end
            rvalid_s[p] = (raddr_s[p] != 5'd0) && (32'(raddr_s[p]) < 32'(NUM_WORDS));
            if (WriteBypass && (state_r == ST_IDLE) && rvalid_s[p] &&
                we_b_i && (raddr_s[p] == waddr_b_i)) begin
                rdata_o[DataWidth*p +: DataWidth] = wdata_b_i;
            end else if (WriteBypass && (state_r == ST_IDLE) && rvalid_s[p] &&
                         we_a_i && (raddr_s[p] == waddr_a_i)) begin
                rdata_o[DataWidth*p +: DataWidth] = wdata_a_i;
            end else begin
                rdata_o[DataWidth*p +: DataWidth] = rstore_s[p];
            end
        end
    end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed bench for ibex_register_file_mp. Three instances share the same
// stimulus: u0 (32 regs, bypass), u1 (32 regs, no bypass), u2 (RV32E, bypass).
module tb_ibex_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        test_en;
    logic [9:0]  raddr;
    logic [4:0]  waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        we_a, we_b, scrub_req;
    logic [63:0] rdata0, rdata1, rdata2;
    logic        busy0, busy1, busy2, done0, done1, done2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ibex_register_file_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .WriteBypass(1'b1)) u0 (
        .clk_i(clk), .rst_ni(rst_ni), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata0),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .scrub_req_i(scrub_req), .scrub_busy_o(busy0), .scrub_done_o(done0));

    ibex_register_file_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .WriteBypass(1'b0)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata1),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .scrub_req_i(scrub_req), .scrub_busy_o(busy1), .scrub_done_o(done1));

    ibex_register_file_mp #(.RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .WriteBypass(1'b1)) u2 (
        .clk_i(clk), .rst_ni(rst_ni), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata2),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .scrub_req_i(scrub_req), .scrub_busy_o(busy2), .scrub_done_o(done2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    task automatic idle_writes;
        we_a = 1'b0; we_b = 1'b0; scrub_req = 1'b0;
    endtask

    int busy_win0, busy_win2, done0_cnt, done2_cnt, last_busy0, done0_idx, busy_after;

    initial begin
        rst_ni = 1'b0; test_en = 1'b0; raddr = '0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
        idle_writes();
        repeat (3) tick();
        rst_ni = 1'b1;
        #1;

        // Reset state
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        chk("rst_done2", {31'd0, done2}, 32'd0);
        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(31 - r));
            chk("rst_rd_p0", rdata0[31:0], 32'd0);
            chk("rst_rd_p1", rdata0[63:32], 32'd0);
        end

        // Single write through port A, with and without bypass
        tick();
        waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; we_a = 1'b1;
        rd(5'd5, 5'd0);
        chk("byp_a_u0", rdata0[31:0], 32'hDEADBEEF);
        chk("nobyp_a_u1", rdata1[31:0], 32'd0);
        chk("byp_a_u2", rdata2[31:0], 32'hDEADBEEF);
        chk("byp_x0_u0", rdata0[63:32], 32'd0);
        tick();
        idle_writes();
        rd(5'd0, 5'd5);
        chk("wr_a_u0", rdata0[63:32], 32'hDEADBEEF);
        chk("wr_a_u1", rdata1[63:32], 32'hDEADBEEF);

        // Same address on both ports: B wins
        waddr_a = 5'd7; wdata_a = 32'h11111111; we_a = 1'b1;
        waddr_b = 5'd7; wdata_b = 32'h22222222; we_b = 1'b1;
        rd(5'd7, 5'd7);
        chk("byp_prio_u0", rdata0[31:0], 32'h22222222);
        chk("nobyp_prio_u1", rdata1[31:0], 32'd0);
        tick();
        idle_writes();
        rd(5'd7, 5'd5);
        chk("prio_u0", rdata0[31:0], 32'h22222222);
        chk("prio_u1", rdata1[31:0], 32'h22222222);

        // Different addresses: both written
        waddr_a = 5'd3; wdata_a = 32'h33333333; we_a = 1'b1;
        waddr_b = 5'd4; wdata_b = 32'h44444444; we_b = 1'b1;
        rd(5'd3, 5'd4);
        chk("byp_dual_a_u0", rdata0[31:0], 32'h33333333);
        chk("byp_dual_b_u0", rdata0[63:32], 32'h44444444);
        tick();
        idle_writes();
        rd(5'd3, 5'd4);
        chk("dual_a_u1", rdata1[31:0], 32'h33333333);
        chk("dual_b_u1", rdata1[63:32], 32'h44444444);
        chk("dual_b_u2", rdata2[63:32], 32'h44444444);

        // Writes to x0 on both ports are discarded, bypass included
        waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF; we_a = 1'b1;
        waddr_b = 5'd0; wdata_b = 32'hFFFFFFFF; we_b = 1'b1;
        rd(5'd0, 5'd0);
        chk("x0_byp_u0", rdata0[31:0], 32'd0);
        chk("x0_byp_u2", rdata2[63:32], 32'd0);
        tick();
        idle_writes();
        rd(5'd0, 5'd0);
        chk("x0_u0", rdata0[31:0], 32'd0);
        chk("x0_u1", rdata1[31:0], 32'd0);

        // RV32E: x20 is out of range for writes, reads and bypass
        waddr_a = 5'd20; wdata_a = 32'h12345678; we_a = 1'b1;
        rd(5'd20, 5'd4);
        chk("x20_byp_u2", rdata2[31:0], 32'd0);
        chk("x20_byp_u0", rdata0[31:0], 32'h12345678);
        tick();
        idle_writes();
        rd(5'd20, 5'd4);
        chk("x20_u2", rdata2[31:0], 32'd0);
        chk("x20_u0", rdata0[31:0], 32'h12345678);
        chk("x4_alias_u2", rdata2[63:32], 32'h44444444);

        // Fill x1..x31 with their index
        for (int r = 1; r < 32; r++) begin
            waddr_a = 5'(r); wdata_a = 32'(r); we_a = 1'b1;
            tick();
        end
        // Scrub request; the write in the request cycle is still performed
        waddr_a = 5'd9; wdata_a = 32'h00000099; we_a = 1'b1; scrub_req = 1'b1;
        tick();
        // First SCRUB cycle: drop a write, ignore a repeated request
        waddr_a = 5'd9; wdata_a = 32'h0000AAAA; we_a = 1'b1; scrub_req = 1'b1;
        rd(5'd9, 5'd1);
        chk("scr_busy0_start", {31'd0, busy0}, 32'd1);
        chk("scr_busy2_start", {31'd0, busy2}, 32'd1);
        chk("scr_done0_start", {31'd0, done0}, 32'd0);
        chk("scr_reqwr_x9", rdata0[31:0], 32'h00000099);
        chk("scr_x1_intact", rdata0[63:32], 32'd1);

        busy_win0 = 1; busy_win2 = 1; done0_cnt = 0; done2_cnt = 0;
        last_busy0 = 1; done0_idx = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            idle_writes();
            if (busy0) begin busy_win0++; last_busy0 = i + 2; end
            if (busy2) busy_win2++;
            if (done0) begin done0_cnt++; done0_idx = i + 2; end
            if (done2) done2_cnt++;
            if (i == 3) begin
                // After four clear edges: x1..x4 zero, x5 onward intact
                rd(5'd4, 5'd5);
                chk("mid_x4_u0", rdata0[31:0], 32'd0);
                chk("mid_x5_u0", rdata0[63:32], 32'd5);
                chk("mid_x4_u2", rdata2[31:0], 32'd0);
                chk("mid_x5_u2", rdata2[63:32], 32'd5);
                rd(5'd1, 5'd9);
                chk("mid_x1_u0", rdata0[31:0], 32'd0);
                chk("mid_x9_drop", rdata0[63:32], 32'h00000099);
            end
            if (done0_cnt > 0 && !done0) break;
        end
        chk("scr_busy_cycles_u0", 32'(busy_win0), 32'd31);
        chk("scr_busy_cycles_u2", 32'(busy_win2), 32'd15);
        chk("scr_done_pulses_u0", 32'(done0_cnt), 32'd1);
        chk("scr_done_pulses_u2", 32'(done2_cnt), 32'd1);
        chk("scr_last_busy_edge", 32'(last_busy0), 32'd31);
        chk("scr_done_edge", 32'(done0_idx), 32'd32);
        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(r & 15));
            chk("post_scr_u0", rdata0[31:0], 32'd0);
            chk("post_scr_u2", rdata2[63:32], 32'd0);
        end

        // Writes accepted again after the scrub
        waddr_a = 5'd20; wdata_a = 32'h00002020; we_a = 1'b1;
        tick();
        idle_writes();
        scrub_req = 1'b1;
        tick();
        scrub_req = 1'b0;
        repeat (9) tick();
        rd(5'd20, 5'd0);
        chk("rst_mid_pre_x20", rdata0[31:0], 32'h00002020);
        chk("rst_mid_pre_busy", {31'd0, busy0}, 32'd1);
        // Asynchronous reset mid-scrub
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_mid_busy2", {31'd0, busy2}, 32'd0);
        chk("rst_mid_done0", {31'd0, done0}, 32'd0);
        chk("rst_mid_x20", rdata0[31:0], 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        done0_cnt = 0; done2_cnt = 0; busy_after = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done0) done0_cnt++;
            if (done2) done2_cnt++;
            if (busy0 || busy2) busy_after++;
        end
        chk("rst_no_done_u0", 32'(done0_cnt), 32'd0);
        chk("rst_no_done_u2", 32'(done2_cnt), 32'd0);
        chk("rst_no_resume", 32'(busy_after), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_register_file_mp.md
Name: ibex_register_file_mp

Overview:
Parametrised flip-flop register file, successor to the single-write, two-read Ibex register file. It provides:
- N read ports, each an AND-OR select mux.
- Two write ports with fixed priority.
- Optional same-cycle write-to-read bypass.
- A sequential scrub engine that zeroes every architectural register on request, used for context switch or security wipe.
It sits in the ID stage in place of the current register file.

Parameters:
RV32E, 0, 1 selects 16 registers (ADDR_WIDTH=4), 0 selects 32 registers (ADDR_WIDTH=5); NUM_WORDS=2**ADDR_WIDTH.
DataWidth, 32, register width in bits.
NumReadPorts, 2, number of read ports; legal range 1..4.
WriteBypass, 1, 1 enables same-cycle forwarding of write data to matching read ports.

Ports:
clk_i  in  1  clock, all state updates on rising edge.
rst_ni  in  1  asynchronous active-low reset.
test_en_i  in  1  test enable; no functional effect, kept for interface compatibility.
raddr_i  in  NumReadPorts*5  read addresses; port p uses bits [5p+4:5p].
rdata_o  out  NumReadPorts*DataWidth  read data; port p uses bits [DataWidth*(p+1)-1:DataWidth*p].
waddr_a_i  in  5  write port A address.
wdata_a_i  in  DataWidth  write port A data.
we_a_i  in  1  write port A enable.
waddr_b_i  in  5  write port B address.
wdata_b_i  in  DataWidth  write port B data.
we_b_i  in  1  write port B enable; B has priority over A.
scrub_req_i  in  1  single-cycle or level request to zero all registers.
scrub_busy_o  out  1  high while the scrub is in progress.
scrub_done_o  out  1  one-cycle pulse when the scrub completes.

Behaviour:
Reset:
- Asserting rst_ni low clears all registers to 0, FSM to IDLE, scrub counter to 0, scrub_busy_o=0, scrub_done_o=0.
- Takes effect immediately, including mid-scrub; no scrub resumes after reset.

Register 0:
- Hard-wired 0; writes to address 0 are discarded.
- Reads of address 0 return 0, including under bypass.

Address range:
- RV32E=1: any write with waddr[4]=1 is discarded.
- RV32E=1: any read with raddr[4]=1 returns 0.

Write:
- Registered; data is visible on reads one cycle after the enabling edge.
- we_a_i and we_b_i hitting the same non-zero address in one cycle: port B data is stored.
- Different addresses: both are written in the same cycle.

Read:
- Combinational; rdata = OR over r of (reg[r] AND (raddr==r)).
- No dynamic index mux.

Bypass (WriteBypass=1, FSM in IDLE):
- If raddr_p is non-zero and valid and equals waddr_b_i with we_b_i, rdata_p = wdata_b_i.
- Otherwise, if it equals waddr_a_i with we_a_i, rdata_p = wdata_a_i.
- Otherwise the stored value is returned.
- WriteBypass=0: stored value only.

Scrub FSM, states IDLE, SCRUB, DONE:
- IDLE: scrub_req_i=1 at a rising edge moves to SCRUB with counter=1. Any port writes in that same cycle are still performed.
- SCRUB: each cycle clears reg[counter] and increments the counter. When counter==NUM_WORDS-1, that register is cleared and the FSM moves to DONE.
  - Duration: exactly NUM_WORDS-1 cycles (31, or 15 for RV32E).
- DONE: lasts one cycle, then IDLE.
- scrub_busy_o = (state==SCRUB).
- scrub_done_o = (state==DONE), registered.
- While in SCRUB:
  - Both write ports are ignored (dropped, not queued).
  - Bypass is disabled.
  - Reads return current stored contents, i.e. cleared registers read 0 and not-yet-cleared registers read their old value.
- scrub_req_i while in SCRUB or DONE is ignored; no restart or queueing.
- Writes in the DONE cycle are accepted normally.
- Counter width is ADDR_WIDTH; there is no wrap beyond NUM_WORDS-1.

Test Plan:
- Reset release, read all 32 addresses on all ports -> all rdata 0; busy=0, done=0.
- Write A x5=0xDEADBEEF -> read x5 next cycle = 0xDEADBEEF. Same cycle, WriteBypass=1: rdata on raddr=5 = 0xDEADBEEF. WriteBypass=0: old value 0.
- Simultaneous writes, A x7=0x11111111 and B x7=0x22222222 -> x7=0x22222222. Repeat with A x3, B x4 -> both written.
- Write x0=0xFFFFFFFF on both ports -> x0 reads 0, with and without bypass. RV32E=1: write x20 discarded, read x20 returns 0.
- Fill x1..x31 with index values, pulse scrub_req_i:
  - busy high for 31 cycles.
  - Mid-scrub reads show x1..xk zero and the rest intact.
  - we_a_i x9=0xAAAA during busy is dropped.
  - done pulses 1 cycle after busy falls; all registers 0.
  - RV32E: 15 cycles.
- Start scrub, assert rst_ni low at cycle 10 -> immediately all registers 0, busy=0. After release no done pulse; second scrub_req_i during busy has no effect on duration.
